// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing controller and its arbiter.
// Holds the FSM state codes, default sizes and the watchdog width helper.
package mul_share_pkg;

    // FSM state encoding, kept as plain 2-bit constants so older blocks can reuse it
    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Default sizes for a four-requester, 3-bit-operand instance
    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 3;
    localparam int DEF_TIMEOUT = 31;

    // Width of a counter that can hold the value TIMEOUT
    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // Index width for a requester vector; never narrower than one bit
    function automatic int idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or above ptr,
// wrapping modulo NREQ, wins. Shared with other single-instance ALU resources.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            found
);

    // Rotating priority search starting at ptr
    always_comb begin
        int          cand;
        logic [PW-1:0] cand_idx;
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = cand[PW-1:0];
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one multi-cycle multiplier among NREQ ALU requesters: picks a
// requester round-robin, issues the operands with a one-cycle start, waits
// for done under a watchdog, then returns the product to that requester.
//
//   state | meaning
//   IDLE  | no operation in flight; arbitrate on req
//   ISSUE | gnt and mul_start pulse for the chosen requester
//   WAIT  | waiting for mul_done; watchdog counts toward TIMEOUT
//   RESP  | rsp_valid pulse with product or timeout error; advance ptr
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [2*W-1:0]      rsp_data,
    output logic                rsp_err,
    output logic                busy,
    output logic                mul_start,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    input  logic                mul_done,
    input  logic [2*W-1:0]      mul_p
);

    localparam int PW  = idx_width(NREQ);
    localparam int WDW = wd_width(TIMEOUT);

    // Last watchdog value before the wait is abandoned
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [PW-1:0]  PTR_TOP = PW'(NREQ - 1);

    logic [1:0]      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel_idx;
    logic [NREQ-1:0] sel_oh;
    logic [WDW-1:0]  wd;

    logic [NREQ-1:0] arb_grant;
    logic [PW-1:0]   arb_idx;
    logic            arb_found;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // Operand mux driven by the one-hot arbiter result
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    // Sequencing FSM; every output is a flop so downstream timing is clean
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            sel_idx   <= '0;
            sel_oh    <= '0;
            wd        <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        gnt       <= arb_grant;
                        sel_oh    <= arb_grant;
                        sel_idx   <= arb_idx;
                        mul_a     <= a_sel;
                        mul_b     <= b_sel;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gnt       <= '0;
                    mul_start <= 1'b0;
                    wd        <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the last watchdog cycle still counts as success
                    if (mul_done) begin
                        rsp_valid <= sel_oh;
                        rsp_data  <= mul_p;
                        rsp_err   <= 1'b0;
                        state     <= ST_RESP;
                    end else if (wd == WD_LAST) begin
                        rsp_valid <= sel_oh;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                ST_RESP: begin
                    rsp_valid <= '0;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    ptr       <= (sel_idx == PTR_TOP) ? '0 : sel_idx + PW'(1);
                    state     <= ST_IDLE;
                end
                default: begin
                    gnt       <= '0;
                    rsp_valid <= '0;
                    mul_start <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl: a behavioural multiplier with a
// programmable response delay, and a transaction-level reference for the
// round-robin order, response timing and product.
module tb_mul_share_ctrl;

    localparam int NREQ    = 4;
    localparam int W       = 3;
    localparam int TIMEOUT = 31;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rsp_valid;
    logic [2*W-1:0]      rsp_data;
    logic                rsp_err;
    logic                busy;
    logic                mul_start;
    logic [W-1:0]        mul_a;
    logic [W-1:0]        mul_b;
    logic                mul_done;
    logic [2*W-1:0]      mul_p;

    mul_share_ctrl #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_p     (mul_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural multiplier: answers k cycles after WAIT entry, or never if k<0
    int               mul_delay = -1;
    int               mdl_cnt   = -1;
    bit               force_en  = 1'b0;
    logic [2*W-1:0]   force_p   = '0;
    logic [2*W-1:0]   mdl_a     = '0;
    logic [2*W-1:0]   mdl_b     = '0;
    logic             mdl_done  = 1'b0;
    logic [2*W-1:0]   mdl_p     = '0;
    logic             stray_done = 1'b0;
    logic [2*W-1:0]   stray_p    = '0;

    assign mul_done = mdl_done | stray_done;
    assign mul_p    = stray_done ? stray_p : mdl_p;

    always @(negedge clk) begin
        mdl_done = 1'b0;
        mdl_p    = '0;
        if (mdl_cnt == 0) begin
            mdl_done = 1'b1;
            mdl_p    = force_en ? force_p : mdl_a * mdl_b;
        end
        if (mdl_cnt >= 0) mdl_cnt = mdl_cnt - 1;
        if (mul_start && mul_delay >= 0) begin
            mdl_cnt = mul_delay;
            mdl_a   = {{W{1'b0}}, mul_a};
            mdl_b   = {{W{1'b0}}, mul_b};
        end
    end

    // Reference state: round-robin pointer and per-requester operands
    int           mptr = 0;
    logic [W-1:0] opa [NREQ];
    logic [W-1:0] opb [NREQ];

    function automatic int ref_pick(input logic [NREQ-1:0] r, input int p);
        logic [NREQ-1:0] t;
        for (int i = 0; i < NREQ; i++) begin
            t = r >> ((p + i) % NREQ);
            if (t[0]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = W'($urandom);
            opb[i] = W'($urandom);
        end
        drive_ops();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_wait_expired", 32'(busy), 32'd0);
    endtask

    // One full request/response; k is the multiplier delay after WAIT entry
    task automatic do_txn(input logic [NREQ-1:0] r, input int k);
        int             g;
        int             exp_n;
        bit             tmo;
        bit             early;
        logic [2*W-1:0] exp_p;
        wait_idle();
        mul_delay = k;
        g = ref_pick(r, mptr);
        req = r;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(1 << g));
        chk("mul_start", 32'(mul_start), 32'd1);
        chk("mul_a", 32'(mul_a), 32'(opa[g]));
        chk("mul_b", 32'(mul_b), 32'(opb[g]));
        chk("busy_issue", 32'(busy), 32'd1);
        req = '0;
        tmo   = (k < 0) || (k >= TIMEOUT);
        exp_n = tmo ? TIMEOUT + 1 : k + 2;
        if (tmo)           exp_p = '0;
        else if (force_en) exp_p = force_p;
        else               exp_p = (2*W)'(int'(opa[g]) * int'(opb[g]));
        early = 1'b0;
        for (int i = 1; i < exp_n; i++) begin
            @(negedge clk);
            if (rsp_valid != '0 || gnt != '0 || mul_start || !busy) early = 1'b1;
        end
        chk("quiet_during_wait", 32'(early), 32'd0);
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << g));
        chk("rsp_data", 32'(rsp_data), 32'(exp_p));
        chk("rsp_err", 32'(rsp_err), 32'(tmo));
        @(negedge clk);
        chk("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        mptr = (g + 1) % NREQ;
    endtask

    logic [NREQ-1:0] rr;
    int              last_g;
    int              g;
    int              n;
    bit              bad;

    initial begin
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        drive_ops();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(|{gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_a, mul_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stray done in IDLE must not disturb anything
        stray_p    = 6'd42;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (|{gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_a, mul_b}) bad = 1'b1;
        end
        chk("stray_done_idle", 32'(bad), 32'd0);

        // Fairness: two requesters held continuously
        opa[0] = 3'd7; opb[0] = 3'd7;
        opa[2] = 3'd7; opb[2] = 3'd7;
        drive_ops();
        mul_delay = $urandom_range(0, 4);
        req    = 4'b0101;
        last_g = -100;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (gnt == '0 && n < 60);
            g = ref_pick(4'b0101, mptr);
            chk("fair_gnt", 32'(gnt), 32'(1 << g));
            if (k > 0) chk("fair_spacing_ge4", 32'((cyc - last_g) >= 4), 32'd1);
            last_g = cyc;
            n = 0;
            do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 60);
            if (k == 3) req = '0;
            chk("fair_rsp_valid", 32'(rsp_valid), 32'(1 << g));
            chk("fair_rsp_data", 32'(rsp_data), 32'd49);
            mptr = (g + 1) % NREQ;
        end

        // Single request with the multiplier answering 6 cycles after start
        opa[1] = 3'd3; opb[1] = 3'd5;
        drive_ops();
        do_txn(4'b0010, 5);

        // Timeout, then a normal request
        rand_ops();
        do_txn(4'b1000, -1);
        rand_ops();
        do_txn(4'b0001, 2);

        // Done on the final watchdog cycle wins over timeout
        rand_ops();
        force_en = 1'b1;
        force_p  = 6'd12;
        do_txn(4'b0100, TIMEOUT - 1);
        force_en = 1'b0;

        // Reset while in WAIT; the late done must be ignored
        wait_idle();
        rand_ops();
        mul_delay = 4;
        req = 4'b0100;
        @(negedge clk);
        chk("rstwait_gnt", 32'(gnt), 32'(1 << ref_pick(4'b0100, mptr)));
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstwait_outputs", 32'(|{gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_a, mul_b}), 32'd0);
        mptr = 0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) bad = 1'b1;
        end
        chk("rstwait_no_rsp", 32'(bad), 32'd0);
        rand_ops();
        do_txn(4'b1111, 3);

        // Randomized traffic, including late dones that land in RESP/IDLE/ISSUE
        mul_delay = -1;
        for (int i = 0; i < 24; i++) begin
            rr = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            rand_ops();
            if ($urandom_range(0, 7) == 0) do_txn(rr, -1);
            else                           do_txn(rr, $urandom_range(0, TIMEOUT + 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
